// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for the latch-based FIFO storage array.
// Drives row strobes/addresses into the bank; holds no data itself.
module fifo_ctrl #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned AF_LEVEL = 6,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_strobe,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned CW = ADDR_W + 1;

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          wr_acc, rd_acc;

    // Full and empty are exclusive, so a simultaneous accept leaves count unchanged.
    always_comb begin
        wr_acc   = wr_en & ~full_q & ~clr;
        rd_acc   = rd_en & ~empty_q & ~clr;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = wr_en & full_q & ~clr;
        udf_d    = rd_en & empty_q & ~clr;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + CW'(wr_acc);
            rd_ptr_d = rd_ptr_q + CW'(rd_acc);
            count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CW'(AF_LEVEL));
        ae_d    = (count_d <= CW'(AE_LEVEL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Strobes are also masked while rst is held so no row is touched during reset.
    assign wr_strobe    = wr_acc & ~rst;
    assign rd_strobe    = rd_acc & ~rst;
    assign wr_addr      = wr_ptr_q[ADDR_W-1:0];
    assign rd_addr      = rd_ptr_q[ADDR_W-1:0];
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: the driver pushes the expected per-cycle output
// vector, a monitor pops and compares it while the inputs are stable.
module tb_fifo_ctrl;

    typedef struct packed {
        logic       ws;
        logic       rs;
        logic [2:0] wa;
        logic [2:0] ra;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic [3:0] cnt;
        logic       ovf;
        logic       udf;
    } obs_t;

    logic       clk, rst, clr, wr_en, rd_en;
    logic       wr_strobe, rd_strobe, full, empty, almost_full, almost_empty;
    logic       overflow, underflow;
    logic [2:0] wr_addr, rd_addr;
    logic [3:0] count;

    int checks   = 0;
    int failures = 0;
    obs_t exp_q[$];

    // Reference state
    int m_wp, m_rp, m_cnt;
    logic m_ovf, m_udf;

    fifo_ctrl #(.DEPTH(8), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .rd_addr(rd_addr),
        .rd_strobe(rd_strobe), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic obs_t model_obs(input logic w, input logic r, input logic c, input logic in_rst);
        obs_t o;
        logic wacc, racc;
        wacc   = w && (m_cnt != 8) && !c && !in_rst;
        racc   = r && (m_cnt != 0) && !c && !in_rst;
        o.ws   = wacc;
        o.rs   = racc;
        o.wa   = 3'(m_wp % 8);
        o.ra   = 3'(m_rp % 8);
        o.full = (m_cnt == 8);
        o.empty = (m_cnt == 0);
        o.af   = (m_cnt >= 6);
        o.ae   = (m_cnt <= 2);
        o.cnt  = 4'(m_cnt);
        o.ovf  = m_ovf;
        o.udf  = m_udf;
        return o;
    endfunction

    function automatic void model_reset();
        m_wp = 0; m_rp = 0; m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
    endfunction

    function automatic void model_step(input logic w, input logic r, input logic c);
        logic wacc, racc;
        wacc  = w && (m_cnt != 8) && !c;
        racc  = r && (m_cnt != 0) && !c;
        m_ovf = w && (m_cnt == 8) && !c;
        m_udf = r && (m_cnt == 0) && !c;
        if (c) begin
            m_wp = 0; m_rp = 0; m_cnt = 0;
        end else begin
            m_wp  = (m_wp + (wacc ? 1 : 0)) % 16;
            m_rp  = (m_rp + (racc ? 1 : 0)) % 16;
            m_cnt = m_cnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
        end
    endfunction

    // One clock cycle of stimulus; expectation is queued before the monitor samples.
    task automatic cycle(input logic w, input logic r, input logic c);
        @(negedge clk);
        wr_en = w; rd_en = r; clr = c;
        exp_q.push_back(model_obs(w, r, c, 1'b0));
        model_step(w, r, c);
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
        model_reset();
        exp_q.push_back(model_obs(1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    // Monitor: compares the visible outputs against the queued expectation.
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = '{wr_strobe, rd_strobe, wr_addr, rd_addr, full, empty,
                      almost_full, almost_empty, count, overflow, underflow};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs: got %h expected %h at %0t", a, e, $time);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        model_reset();
        reset_cycle();
        reset_cycle();
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(model_obs(1'b0, 1'b0, 1'b0, 1'b0));
        model_step(1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        #3 chk("idle_count", int'(count), 0);
        chk("idle_empty", int'(empty), 1);

        // Fill to full, then one rejected write
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            #3 chk("fill_wr_addr", int'(wr_addr), i);
        end
        cycle(1'b1, 1'b0, 1'b0);
        #3 chk("full_flag", int'(full), 1);
        chk("full_count", int'(count), 8);
        chk("full_af", int'(almost_full), 1);
        cycle(1'b0, 1'b0, 1'b0);
        #3 chk("overflow_pulse", int'(overflow), 1);
        chk("overflow_count", int'(count), 8);
        cycle(1'b0, 1'b0, 1'b0);
        #3 chk("overflow_gone", int'(overflow), 0);

        // Drain to empty, then one rejected read
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            #3 chk("drain_rd_addr", int'(rd_addr), i);
        end
        cycle(1'b0, 1'b1, 1'b0);
        #3 chk("empty_flag", int'(empty), 1);
        cycle(1'b0, 1'b0, 1'b0);
        #3 chk("underflow_pulse", int'(underflow), 1);
        cycle(1'b0, 1'b0, 1'b0);

        // Steady state at count 4 with simultaneous read and write
        repeat (4) cycle(1'b1, 1'b0, 1'b0);
        repeat (20) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        #3 chk("hold_count", int'(count), 4);

        // Flush at count 5 with a concurrent write
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        #3 chk("clr_no_strobe", int'(wr_strobe), 0);
        cycle(1'b0, 1'b0, 1'b0);
        #3 chk("clr_count", int'(count), 0);
        chk("clr_no_overflow", int'(overflow), 0);

        // Full boundary: read wins, write overflows
        repeat (8) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        #3 chk("fullb_count", int'(count), 7);
        chk("fullb_ovf", int'(overflow), 1);

        // Empty boundary: write wins, read underflows
        repeat (7) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        #3 chk("emptyb_count", int'(count), 1);
        chk("emptyb_udf", int'(underflow), 1);

        // Asynchronous reset in the middle of a write burst at count 3
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b0; clr = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        exp_q.push_back(model_obs(1'b1, 1'b0, 1'b0, 1'b1));
        #2 chk("async_rst_count", int'(count), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(model_obs(1'b1, 1'b0, 1'b0, 1'b0));
        model_step(1'b1, 1'b0, 1'b0);
        #3 chk("post_rst_wr_addr", int'(wr_addr), 0);
        chk("post_rst_strobe", int'(wr_strobe), 1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #4;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller for the latch-based FIFO storage array. It arbitrates write and read requests against the array's occupancy and drives the row write strobe and the read/write row addresses into the storage cells. It publishes registered full/empty/almost flags, an occupancy count, and single-cycle overflow/underflow error pulses. It sits between the producer/consumer handshake and the storage bank; it holds no data itself.

## Interface
- DEPTH, 8, number of storage rows; must be a power of two, at least 2
- ADDR_W, 3, row address width; must equal log2(DEPTH)
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous flush
- wr_en  in  1  producer write request
- rd_en  in  1  consumer read request
- wr_strobe  out  1  row write enable to storage; combinational, equals wr_acc
- wr_addr  out  ADDR_W  row written this cycle; equals wr_ptr[ADDR_W-1:0]
- rd_addr  out  ADDR_W  row presented to the read mux; equals rd_ptr[ADDR_W-1:0]
- rd_strobe  out  1  read accepted this cycle; combinational, equals rd_acc
- full  out  1  registered
- empty  out  1  registered
- almost_full  out  1  registered
- almost_empty  out  1  registered
- count  out  ADDR_W+1  occupancy, 0..DEPTH, registered
- overflow  out  1  one-cycle pulse for a rejected write
- underflow  out  1  one-cycle pulse for a rejected read

## Operation
- wr_ptr and rd_ptr are each ADDR_W+1 bits. The MSB is the wrap bit, and each pointer increments modulo 2·DEPTH.
- Acceptance: wr_acc = wr_en & ~full & ~clr; rd_acc = rd_en & ~empty & ~clr.
- Full and empty are mutually exclusive, so both can be accepted in the same cycle. In that case count is unchanged and both pointers advance.
- Next-state count = count + wr_acc − rd_acc. This is computed at ADDR_W+1 bits and never exceeds DEPTH or goes below 0.
- Flags are derived from next-state count and registered:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count >= AF_LEVEL)
  - almost_empty = (count <= AE_LEVEL)
- Error pulses are registered, so each appears on the cycle after the offending request:
  - overflow = wr_en & full & ~clr
  - underflow = rd_en & empty & ~clr
- clr has priority over wr_en and rd_en. On clr:
  - pointers go to 0 and count goes to 0
  - empty=1, almost_empty=1, all other flags 0
  - no strobes fire and no error pulses are generated in that cycle
- Read data is taken from the storage at rd_addr while rd_strobe is high; rd_ptr advances at that clock edge.

## Timing
- Reset (rst=1, asynchronous, takes effect immediately):
  - wr_ptr=0, rd_ptr=0, count=0
  - empty=1, almost_empty=1
  - full=0, almost_full=0, overflow=0, underflow=0
  - wr_strobe=0 and rd_strobe=0, because they are gated by the reset state of the flags and by rst
- Reset mid-operation: all state is discarded. The first request after deassertion is evaluated against the empty state.
- Write latency: a write accepted in cycle N makes empty=0 in cycle N+1, and that row is readable from N+1 onward.
- Read latency: data at rd_addr is valid combinationally in the same cycle as rd_strobe.
- Full boundary: with count=DEPTH and wr_en=1, rd_en=1, the read is accepted and the write is rejected. Next state: count=DEPTH−1, full=0, overflow=1.
- Empty boundary: with count=0 and wr_en=1, rd_en=1, only the write is accepted. Next state: count=1, underflow=1.
- Wrap-around: after DEPTH writes and DEPTH reads, both pointers equal DEPTH (MSB=1, address bits 0), and full/empty decode correctly.

## Test plan
- Reset, then idle 3 cycles -> empty=1, almost_empty=1, count=0, full=0, no strobes.
- Write 8 consecutive times with DEPTH=8 -> wr_addr steps 0..7; full=1 after the 8th edge; almost_full=1 once count reaches 6; a 9th write gives overflow=1 for one cycle with count still 8.
- From full, read 8 consecutive times -> rd_addr steps 0..7; empty=1 after the last; a further read gives underflow=1 for one cycle.
- Hold count=4 and issue wr_en=rd_en=1 for 20 cycles -> count stays 4, both addresses wrap 7->0 at least twice, and flags stay static.
- At count=5, assert clr together with wr_en=1 -> no wr_strobe; count=0 and empty=1 on the next edge; no overflow pulse.
- Assert rst asynchronously mid-burst at count=3 -> outputs return to reset values before the next clock edge, and the first write after release lands at wr_addr=0.
